// File: rtl/tcm_sram_arb_pkg.sv
// Shared defaults and helpers for the banked TCM SRAM subsystem.
// Widths derived from these defaults live in the modules that use them.
package tcm_sram_arb_pkg;

  localparam int TCM_DW         = 32;
  localparam int TCM_AW         = 14;
  localparam int TCM_BANKS      = 2;
  localparam int TCM_STARVE_MAX = 3;

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tcm_sram_arb_bank.sv
// One single-port TCM bank: byte-masked write, registered read.
// The array carries no reset; only the read register is observed.
module tcm_sram_bank
  import tcm_sram_arb_pkg::*;
#(
  parameter  int DW = TCM_DW,
  parameter  int AW = TCM_AW,
  localparam int MW = DW / 8
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  input  logic [MW-1:0] i_wem,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_en && !i_we) begin
      r_q <= r_mem[i_addr];
    end
    if (i_en && i_we) begin
      for (int i = 0; i < MW; i++) begin
        if (i_wem[i]) begin
          r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/tcm_sram_arb.sv
// Banked TCM front end: IFU/LSU bank arbitration with IFU anti-starvation,
// bank-select response pipeline and per-port read-data hold registers.
module tcm_sram_arb
  import tcm_sram_arb_pkg::*;
#(
  parameter  int DW         = TCM_DW,
  parameter  int AW         = TCM_AW,
  parameter  int BANKS      = TCM_BANKS,
  parameter  int STARVE_MAX = TCM_STARVE_MAX,
  localparam int MW         = DW / 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ifu_req_valid,
  output logic          ifu_req_ready,
  input  logic [AW-1:0] ifu_req_addr,
  output logic          ifu_rsp_valid,
  output logic [DW-1:0] ifu_rsp_rdata,
  input  logic          lsu_req_valid,
  output logic          lsu_req_ready,
  input  logic          lsu_req_we,
  input  logic [AW-1:0] lsu_req_addr,
  input  logic [DW-1:0] lsu_req_wdata,
  input  logic [MW-1:0] lsu_req_wem,
  output logic          lsu_rsp_valid,
  output logic [DW-1:0] lsu_rsp_rdata
);

  localparam int LB  = $clog2(BANKS);
  localparam int BW  = idx_w(BANKS);
  localparam int LAW = AW - LB;
  localparam int SW  = idx_w(STARVE_MAX + 1);

  logic [BW-1:0]  w_ifu_bank, w_lsu_bank;
  logic [LAW-1:0] w_ifu_la, w_lsu_la;
  logic           w_conf, w_ifu_win;
  logic           w_ifu_acc, w_lsu_acc;
  logic [DW-1:0]  w_q [BANKS];
  logic [DW-1:0]  w_ifu_rd, w_lsu_rd;

  logic [SW-1:0]  r_starve;
  logic           r_ifu_vld, r_lsu_vld, r_lsu_rd;
  logic [BW-1:0]  r_ifu_sel, r_lsu_sel;
  logic [DW-1:0]  r_ifu_hold, r_lsu_hold;

  // Word-interleaved: low address bits pick the bank.
  generate
    if (LB == 0) begin : g_one
      assign w_ifu_bank = '0;
      assign w_lsu_bank = '0;
      assign w_ifu_la   = ifu_req_addr;
      assign w_lsu_la   = lsu_req_addr;
    end else begin : g_many
      assign w_ifu_bank = ifu_req_addr[LB-1:0];
      assign w_lsu_bank = lsu_req_addr[LB-1:0];
      assign w_ifu_la   = ifu_req_addr[AW-1:LB];
      assign w_lsu_la   = lsu_req_addr[AW-1:LB];
    end
  endgenerate

  assign w_conf    = ifu_req_valid & lsu_req_valid
                   & (w_ifu_bank == w_lsu_bank);
  assign w_ifu_win = (r_starve == SW'(STARVE_MAX));

  assign ifu_req_ready = ~w_conf | w_ifu_win;
  assign lsu_req_ready = ~w_conf | ~w_ifu_win;
  assign w_ifu_acc     = ifu_req_valid & ifu_req_ready;
  assign w_lsu_acc     = lsu_req_valid & lsu_req_ready;

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic w_isel, w_lsel;
    assign w_isel = w_ifu_acc & (w_ifu_bank == BW'(b));
    assign w_lsel = w_lsu_acc & (w_lsu_bank == BW'(b));
    tcm_sram_bank #(
      .DW (DW),
      .AW (LAW)
    ) u_bank (
      .clk     (clk),
      .i_en    (w_isel | w_lsel),
      .i_we    (w_lsel & lsu_req_we),
      .i_addr  (w_lsel ? w_lsu_la : w_ifu_la),
      .i_wdata (lsu_req_wdata),
      .i_wem   (lsu_req_wem),
      .o_rdata (w_q[b])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve   <= '0;
      r_ifu_vld  <= 1'b0;
      r_lsu_vld  <= 1'b0;
      r_lsu_rd   <= 1'b0;
      r_ifu_hold <= '0;
      r_lsu_hold <= '0;
    end else begin
      r_ifu_vld <= w_ifu_acc;
      r_lsu_vld <= w_lsu_acc;
      r_lsu_rd  <= w_lsu_acc & ~lsu_req_we;
      if (w_ifu_acc) begin
        r_starve <= '0;
      end else if (w_conf && !w_ifu_win) begin
        r_starve <= r_starve + 1'b1;
      end
      if (r_ifu_vld) r_ifu_hold <= w_ifu_rd;
      if (r_lsu_rd)  r_lsu_hold <= w_lsu_rd;
    end
  end

  always_ff @(posedge clk) begin
    r_ifu_sel <= w_ifu_bank;
    r_lsu_sel <= w_lsu_bank;
  end

  assign w_ifu_rd = w_q[r_ifu_sel];
  assign w_lsu_rd = w_q[r_lsu_sel];

  assign ifu_rsp_valid = r_ifu_vld;
  assign lsu_rsp_valid = r_lsu_vld;
  assign ifu_rsp_rdata = r_ifu_vld ? w_ifu_rd : r_ifu_hold;
  assign lsu_rsp_rdata = r_lsu_rd  ? w_lsu_rd : r_lsu_hold;

endmodule

// File: tb/tb_tcm_sram_arb.sv
// Scoreboard bench for tcm_sram_arb: directed scenarios then random traffic
// checked against a word-array memory model and the arbitration rules.
module tb_tcm_sram_arb;

  localparam int DW   = 32;
  localparam int AW   = 14;
  localparam int BN   = 2;
  localparam int SMAX = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifu_req_valid, ifu_req_ready;
  logic [AW-1:0] ifu_req_addr;
  logic          ifu_rsp_valid;
  logic [DW-1:0] ifu_rsp_rdata;
  logic          lsu_req_valid, lsu_req_ready, lsu_req_we;
  logic [AW-1:0] lsu_req_addr;
  logic [DW-1:0] lsu_req_wdata;
  logic [3:0]    lsu_req_wem;
  logic          lsu_rsp_valid;
  logic [DW-1:0] lsu_rsp_rdata;

  always #5 clk = ~clk;

  tcm_sram_arb #(
    .DW         (DW),
    .AW         (AW),
    .BANKS      (BN),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_req_addr  (ifu_req_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_rdata (ifu_rsp_rdata),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_req_we    (lsu_req_we),
    .lsu_req_addr  (lsu_req_addr),
    .lsu_req_wdata (lsu_req_wdata),
    .lsu_req_wem   (lsu_req_wem),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rsp_rdata (lsu_rsp_rdata)
  );

  typedef struct {
    logic        rd;
    logic [31:0] data;
    int          stamp;
  } exp_t;

  exp_t        q_ifu[$];
  exp_t        q_lsu[$];
  logic [31:0] m_mem [int];
  int          m_starve = 0;
  logic [31:0] h_ifu = '0;
  logic [31:0] h_lsu = '0;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Monitor: responses are due exactly one cycle after acceptance.
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (ifu_rsp_valid === 1'b1) begin
      if (q_ifu.size() == 0) begin
        chk1("ifu_spurious_valid", ifu_rsp_valid, 1'b0);
      end else begin
        e = q_ifu.pop_front();
        chk("ifu_rsp_latency", cyc, e.stamp + 1);
        h_ifu = e.data;
      end
    end else if (q_ifu.size() > 0 && q_ifu[0].stamp + 1 <= cyc) begin
      chk1("ifu_rsp_missing", ifu_rsp_valid, 1'b1);
      void'(q_ifu.pop_front());
    end
    chk("ifu_rsp_rdata", ifu_rsp_rdata, h_ifu);
    if (lsu_rsp_valid === 1'b1) begin
      if (q_lsu.size() == 0) begin
        chk1("lsu_spurious_valid", lsu_rsp_valid, 1'b0);
      end else begin
        e = q_lsu.pop_front();
        chk("lsu_rsp_latency", cyc, e.stamp + 1);
        if (e.rd) h_lsu = e.data;
      end
    end else if (q_lsu.size() > 0 && q_lsu[0].stamp + 1 <= cyc) begin
      chk1("lsu_rsp_missing", lsu_rsp_valid, 1'b1);
      void'(q_lsu.pop_front());
    end
    chk("lsu_rsp_rdata", lsu_rsp_rdata, h_lsu);
  end

  // One bus cycle: drive, then judge acceptance from the arbitration rules.
  task automatic step(input logic iv, input logic [AW-1:0] ia,
                      input logic lv, input logic lwe,
                      input logic [AW-1:0] la, input logic [31:0] lwd,
                      input logic [3:0] lwem,
                      output logic i_ok, output logic l_ok);
    logic        conf, iwin, eir, elr;
    logic [31:0] w;
    exp_t        e;
    @(posedge clk);
    #2;
    ifu_req_valid = iv;
    ifu_req_addr  = ia;
    lsu_req_valid = lv;
    lsu_req_we    = lwe;
    lsu_req_addr  = la;
    lsu_req_wdata = lwd;
    lsu_req_wem   = lwem;
    #5;
    conf = iv && lv && ((int'(ia) % BN) == (int'(la) % BN));
    iwin = (m_starve == SMAX);
    eir  = !conf || iwin;
    elr  = !conf || !iwin;
    chk1("ifu_req_ready", ifu_req_ready, eir);
    chk1("lsu_req_ready", lsu_req_ready, elr);
    i_ok = iv && eir;
    l_ok = lv && elr;
    if (i_ok) m_starve = 0;
    else if (conf && m_starve < SMAX) m_starve++;
    if (i_ok) begin
      e.rd    = 1'b1;
      e.data  = m_mem[int'(ia)];
      e.stamp = cyc;
      q_ifu.push_back(e);
    end
    if (l_ok) begin
      w       = m_mem.exists(int'(la)) ? m_mem[int'(la)] : 32'h0;
      e.rd    = !lwe;
      e.data  = w;
      e.stamp = cyc;
      q_lsu.push_back(e);
      if (lwe) begin
        for (int b = 0; b < 4; b++)
          if (lwem[b]) w[8*b +: 8] = lwd[8*b +: 8];
        m_mem[int'(la)] = w;
      end
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int idx;
    idx = $urandom_range(0, 15);
    return (idx < 12) ? AW'(idx) : AW'((1 << AW) - 16 + idx);
  endfunction

  initial begin
    logic          io, lo;
    logic          piv, plv, pwe, pend_i, pend_l;
    logic [AW-1:0] pia, pla;
    logic [31:0]   pwd;
    logic [3:0]    pwem;
    int            pulses;

    rst           = 1'b1;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    ifu_req_addr  = '0;
    lsu_req_addr  = '0;
    lsu_req_we    = 1'b0;
    lsu_req_wdata = '0;
    lsu_req_wem   = '0;
    for (int r = 0; r < 2; r++) begin
      @(posedge clk);
      #1;
      chk1("reset_ifu_valid", ifu_rsp_valid, 1'b0);
      chk1("reset_lsu_valid", lsu_rsp_valid, 1'b0);
      chk("reset_ifu_rdata", ifu_rsp_rdata, 32'h0);
      chk("reset_lsu_rdata", lsu_rsp_rdata, 32'h0);
    end
    #1;
    rst           = 1'b0;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk1("post_reset_ifu_valid", ifu_rsp_valid, 1'b0);
    chk1("post_reset_lsu_valid", lsu_rsp_valid, 1'b0);
    chk("post_reset_ifu_rdata", ifu_rsp_rdata, 32'h0);
    chk("post_reset_lsu_rdata", lsu_rsp_rdata, 32'h0);

    for (int i = 0; i < 16; i++) begin
      pla = (i < 12) ? AW'(i) : AW'((1 << AW) - 16 + i);
      step(0, '0, 1, 1, pla, $urandom, 4'hF, io, lo);
    end

    // Parallel reads in different banks.
    step(1, 14'd4, 1, 0, 14'd7, '0, '0, io, lo);
    chk1("par_ifu_ready", ifu_req_ready, 1'b1);
    chk1("par_lsu_ready", lsu_req_ready, 1'b1);
    step(0, '0, 0, 0, '0, '0, '0, io, lo);
    chk1("par_ifu_rsp_valid", ifu_rsp_valid, 1'b1);
    chk1("par_lsu_rsp_valid", lsu_rsp_valid, 1'b1);
    chk("par_ifu_rdata", ifu_rsp_rdata, m_mem[4]);
    chk("par_lsu_rdata", lsu_rsp_rdata, m_mem[7]);

    // Byte-masked write and readback.
    step(0, '0, 1, 1, 14'd5, 32'hDEADBEEF, 4'hF, io, lo);
    step(0, '0, 1, 1, 14'd5, 32'h0000AA00, 4'b0010, io, lo);
    step(0, '0, 1, 0, 14'd5, '0, '0, io, lo);
    step(0, '0, 0, 0, '0, '0, '0, io, lo);
    chk1("wem_rsp_valid", lsu_rsp_valid, 1'b1);
    chk("wem_readback", lsu_rsp_rdata, 32'hDEADAAEF);

    // Both ports hammer bank 0: LSU,LSU,LSU,IFU repeating.
    for (int k = 0; k < 8; k++) begin
      step(1, 14'd0, 1, 0, 14'd2, '0, '0, io, lo);
      chk1("starve_ifu_ready", ifu_req_ready, (k % 4) == 3);
      chk1("starve_lsu_ready", lsu_req_ready, (k % 4) != 3);
    end

    // IFU wins a same-address race against an LSU write.
    step(0, '0, 1, 1, 14'd8, 32'h11111111, 4'hF, io, lo);
    for (int k = 0; k < 3; k++)
      step(1, 14'd8, 1, 0, 14'd6, '0, '0, io, lo);
    step(1, 14'd8, 1, 1, 14'd8, 32'h22222222, 4'hF, io, lo);
    chk1("race_ifu_ready", ifu_req_ready, 1'b1);
    chk1("race_lsu_ready", lsu_req_ready, 1'b0);
    step(0, '0, 1, 1, 14'd8, 32'h22222222, 4'hF, io, lo);
    chk1("race_ifu_rsp_valid", ifu_rsp_valid, 1'b1);
    chk("race_ifu_old_data", ifu_rsp_rdata, 32'h11111111);
    step(0, '0, 1, 0, 14'd8, '0, '0, io, lo);
    step(0, '0, 0, 0, '0, '0, '0, io, lo);
    chk("race_new_data", lsu_rsp_rdata, 32'h22222222);

    // LSU rdata holds across a write ack and idle cycles.
    step(0, '0, 1, 1, 14'd9, 32'hCAFEF00D, 4'hF, io, lo);
    step(0, '0, 1, 0, 14'd9, '0, '0, io, lo);
    step(0, '0, 1, 1, 14'd10, $urandom, 4'hF, io, lo);
    chk("hold_read", lsu_rsp_rdata, 32'hCAFEF00D);
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      step(0, '0, 0, 0, '0, '0, '0, io, lo);
      if (lsu_rsp_valid === 1'b1) pulses++;
      chk("hold_rdata", lsu_rsp_rdata, 32'hCAFEF00D);
    end
    chk("hold_ack_pulses", pulses, 1);

    // Random traffic; unaccepted requests are held stable.
    pend_i = 1'b0;
    pend_l = 1'b0;
    piv = 1'b0; plv = 1'b0; pwe = 1'b0;
    pia = '0;   pla = '0;   pwd = '0; pwem = '0;
    repeat (600) begin
      if (!pend_i) begin
        piv = ($urandom_range(0, 9) < 7);
        pia = rand_addr();
      end
      if (!pend_l) begin
        plv  = ($urandom_range(0, 9) < 7);
        pwe  = $urandom_range(0, 1) == 1;
        pla  = rand_addr();
        pwd  = $urandom;
        pwem = 4'($urandom_range(0, 15));
      end
      step(piv, pia, plv, pwe, pla, pwd, pwem, io, lo);
      pend_i = piv && !io;
      pend_l = plv && !lo;
    end
    repeat (3) step(0, '0, 0, 0, '0, '0, '0, io, lo);
    chk("drain_ifu_queue", q_ifu.size(), 0);
    chk("drain_lsu_queue", q_lsu.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
